fmul_pipe: RTL and testbench

Parametrised, elastic, pipelined floating-point multiplier for the FloPoCo-style operand format (2-bit exception field, sign, biased exponent, fraction). It generalises the fixed 4/10 combinational-plus-one-register multiplier core. Exponent and fraction widths are parameters, and the datapath has a two-stage valid/ready pipeline with backpressure. Exception fields are handled deterministically, with the exponent and fraction fields forced to zero on non-normal results. It sits between the HLS scheduler's operand FIFOs and result consumers wherever a multiply needs flow control.

---
 rtl/fmul_pkg.sv | 30 +++
 rtl/fmul_pipe_if.sv | 25 ++
 rtl/fmul_round.sv | 50 +++++
 rtl/fmul_pipe.sv | 103 ++++++++++
 tb/tb_fmul_pipe.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fmul_pkg.sv
// rtl/fmul_pkg.sv - exception codes, bias and word-layout helpers for fmul_pipe
package fmul_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    function automatic int fp_bias(int we);
        return (1 << (we - 1)) - 1;
    endfunction

    function automatic int fp_width(int we, int wf);
        return we + wf + 3;
    endfunction

    // Bit positions of each field within a FloPoCo-style word
    function automatic int fp_exc_lsb(int we, int wf);
        return we + wf + 1;
    endfunction

    function automatic int fp_sign_bit(int we, int wf);
        return we + wf;
    endfunction

    function automatic int fp_exp_lsb(int wf);
        return wf;
    endfunction

endpackage

// File: rtl/fmul_pipe_if.sv
// rtl/fmul_pipe_if.sv - operand/result handshake bundle for fmul_pipe
interface fmul_pipe_if #(
    parameter int WE = 4,
    parameter int WF = 10
) ();
    localparam int W = WE + WF + 3;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, R
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, R
    );
endinterface

// File: rtl/fmul_round.sv
// rtl/fmul_round.sv - normalise, round-to-nearest-even and classify a raw product
module fmul_round
    import fmul_pkg::*;
#(
    parameter int WE = 4,
    parameter int WF = 10,
    parameter int W  = WE + WF + 3
) (
    input  logic              sign,
    input  logic [1:0]        pre_exc,
    input  logic [WE+1:0]     expsum,
    input  logic [2*WF+1:0]   prod,
    output logic [W-1:0]      r
);
    logic              norm;
    logic [2*WF+1:0]   aligned;
    logic [WF-1:0]     frac_t;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [WE+1:0]     expnorm;
    logic [WE+WF+1:0]  rounded;
    logic [1:0]        post_exc;
    logic [1:0]        final_exc;

    always_comb begin
        norm     = prod[2*WF+1];
        // Shift so the leading one always sits at the top bit, then drop it
        aligned  = norm ? prod : (prod << 1);
        frac_t   = aligned[2*WF:WF+1];
        guard    = aligned[WF];
        sticky   = |aligned[WF-1:0];
        expnorm  = expsum + {{(WE+1){1'b0}}, norm};
        round_up = guard & (sticky | frac_t[0]);
        rounded  = {expnorm, frac_t} + {{(WE+WF+1){1'b0}}, round_up};

        post_exc = EXC_ZERO;
        case (rounded[WE+WF+1 -: 2])
            2'b00:   post_exc = EXC_NORMAL;
            2'b01:   post_exc = EXC_INF;
            default: post_exc = EXC_ZERO;
        endcase

        final_exc = (pre_exc != EXC_NORMAL) ? pre_exc : post_exc;
        if (final_exc == EXC_NORMAL)
            r = {final_exc, sign, rounded[WE+WF-1:0]};
        else
            r = {final_exc, sign, {(WE+WF){1'b0}}};
    end
endmodule

// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - two-stage elastic floating-point multiplier
module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int WE = 4,
    parameter int WF = 10
) (
    input  logic        clk,
    input  logic        rst,
    fmul_pipe_if.slave  bus
);
    localparam int W        = fp_width(WE, WF);
    localparam int PW       = 2 * WF + 2;
    localparam int EXC_LSB  = fp_exc_lsb(WE, WF);
    localparam int SIGN_BIT = fp_sign_bit(WE, WF);
    localparam int EXP_LSB  = fp_exp_lsb(WF);
    localparam logic [WE+1:0] BIAS = (WE+2)'(fp_bias(WE));

    logic [1:0]    x_exc, y_exc;
    logic [WE-1:0] x_exp, y_exp;
    logic [WF-1:0] x_frac, y_frac;
    logic [PW-1:0] x_sig, y_sig;
    logic [1:0]    pre_exc;
    logic [WE+1:0] expsum;
    logic [PW-1:0] prod;

    logic          s1_valid;
    logic          s1_sign;
    logic [1:0]    s1_exc;
    logic [WE+1:0] s1_expsum;
    logic [PW-1:0] s1_prod;
    logic          s2_valid;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_next;
    logic          s1_load;
    logic          s2_load;

    assign x_exc  = bus.X[EXC_LSB +: 2];
    assign y_exc  = bus.Y[EXC_LSB +: 2];
    assign x_exp  = bus.X[EXP_LSB +: WE];
    assign y_exp  = bus.Y[EXP_LSB +: WE];
    assign x_frac = bus.X[WF-1:0];
    assign y_frac = bus.Y[WF-1:0];

    // Operands widened to the product width so the multiply is full-precision
    assign x_sig  = {{(WF+1){1'b0}}, 1'b1, x_frac};
    assign y_sig  = {{(WF+1){1'b0}}, 1'b1, y_frac};
    assign prod   = x_sig * y_sig;
    assign expsum = {2'b00, x_exp} + {2'b00, y_exp} - BIAS;

    always_comb begin
        pre_exc = EXC_NAN;
        case ({x_exc, y_exc})
            4'b0000, 4'b0001, 4'b0100: pre_exc = EXC_ZERO;
            4'b0101:                   pre_exc = EXC_NORMAL;
            4'b0110, 4'b1001, 4'b1010: pre_exc = EXC_INF;
            default:                   pre_exc = EXC_NAN;
        endcase
    end

    fmul_round #(.WE(WE), .WF(WF), .W(W)) u_round (
        .sign    (s1_sign),
        .pre_exc (s1_exc),
        .expsum  (s1_expsum),
        .prod    (s1_prod),
        .r       (r_next)
    );

    // A stage may load when empty or when its occupant leaves this cycle
    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.R         = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exc    <= EXC_ZERO;
            s1_expsum <= '0;
            s1_prod   <= '0;
            s2_valid  <= 1'b0;
            r_q       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign   <= bus.X[SIGN_BIT] ^ bus.Y[SIGN_BIT];
                    s1_exc    <= pre_exc;
                    s1_expsum <= expsum;
                    s1_prod   <= prod;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    r_q <= r_next;
            end
        end
    end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - directed self-checking bench for fmul_pipe (WE=4, WF=10)
module tb_fmul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_pipe_if #(.WE(4), .WF(10)) bus ();
    fmul_pipe #(.WE(4), .WF(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [16:0] vx [10];
    logic [16:0] vy [10];
    logic [16:0] vr [10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [16:0] x, input logic [16:0] y,
                          input logic [16:0] r);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.X         = x;
        bus.Y         = y;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'(1'b0));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
        check(tag, 32'(bus.R), 32'(r));
    endtask

    initial begin
        int in_idx, out_idx, occ;
        logic prev_stall, fire_in, fire_out;
        logic [16:0] prev_r;

        vx[0] = 17'h09E00; vy[0] = 17'h09E00; vr[0] = 17'h0A080;
        vx[1] = 17'h0E000; vy[1] = 17'h09C00; vr[1] = 17'h0E000;
        vx[2] = 17'h09C01; vy[2] = 17'h09E00; vr[2] = 17'h09E02;
        vx[3] = 17'h09C00; vy[3] = 17'h09C00; vr[3] = 17'h09C00;
        vx[4] = 17'h10000; vy[4] = 17'h0A000; vr[4] = 17'h10000;
        vx[5] = 17'h00000; vy[5] = 17'h10000; vr[5] = 17'h18000;
        vx[6] = 17'h0BC00; vy[6] = 17'h0BC00; vr[6] = 17'h10000;
        vx[7] = 17'h08000; vy[7] = 17'h08000; vr[7] = 17'h00000;
        vx[8] = 17'h04000; vy[8] = 17'h09C00; vr[8] = 17'h04000;
        vx[9] = 17'h18000; vy[9] = 17'h0E000; vr[9] = 17'h1C000;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.X         = '0;
        bus.Y         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("rst_r", 32'(bus.R), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
        rst = 1'b0;

        run_op("mul_1p5", vx[0], vy[0], vr[0]);
        run_op("sign", vx[1], vy[1], vr[1]);
        run_op("tie_even_up", vx[2], vy[2], vr[2]);
        run_op("exact", vx[3], vy[3], vr[3]);
        run_op("inf_x_2", vx[4], vy[4], vr[4]);
        run_op("zero_x_inf", vx[5], vy[5], vr[5]);
        run_op("overflow", vx[6], vy[6], vr[6]);
        run_op("underflow", vx[7], vy[7], vr[7]);
        run_op("neg_zero", vx[8], vy[8], vr[8]);
        run_op("nan_sign", vx[9], vy[9], vr[9]);

        // Let the last result drain before streaming
        @(posedge clk);
        in_idx = 0; out_idx = 0; occ = 0;
        prev_stall = 1'b0; prev_r = '0;
        for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (in_idx < 8);
            if (in_idx < 8) begin
                bus.X = vx[in_idx];
                bus.Y = vy[in_idx];
            end
            #1;
            check("in_ready_rule", 32'(bus.in_ready), 32'(!(occ == 2 && !bus.out_ready)));
            check("no_phantom", 32'(bus.out_valid && occ == 0), 32'(1'b0));
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'(1'b1));
                check("stall_hold", 32'(bus.R), 32'(prev_r));
            end
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                check("stream_r", 32'(bus.R), 32'(vr[out_idx]));
                out_idx++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_r     = bus.R;
            if (fire_in)
                in_idx++;
            occ = occ + int'(fire_in) - int'(fire_out);
        end
        check("stream_count", 32'(out_idx), 32'd8);

        // Fill both stages under backpressure, then reset
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.X = vx[0]; bus.Y = vy[0];
        @(negedge clk);
        bus.X = vx[1]; bus.Y = vy[1];
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("full_in_ready", 32'(bus.in_ready), 32'(1'b0));
        check("full_out_valid", 32'(bus.out_valid), 32'(1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("mid_rst_r", 32'(bus.R), 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_stale", 32'(bus.out_valid), 32'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
